alu_control_mc: RTL and testbench

Parametrised ALU control for the MIPS datapath: decodes ALUOp plus the function field into a widened ALU operation code (adds shifts, SLT, LUI/JAL pass-through) and sequences multi-cycle MULT/MULTU/DIV/DIVU operations on an external iterative multiply/divide unit. It sits between the main control unit, the ALU and the HI/LO unit. While a multi-cycle operation runs it asserts a stall that freezes the PC.

---
 rtl/alu_ctrl_pkg.sv | 46 ++++
 rtl/alu_mc_sequencer.sv | 80 ++++++++
 rtl/alu_control_mc.sv | 92 +++++++++
 tb/tb_alu_control_mc.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared codes for the ALU control block: ALU operation codes, ALUOp classes,
// R-type funct values and the multi-cycle sequencer state encoding.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_NOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_LUI = 4'b0101;
    localparam logic [3:0] OP_JAL = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_SLT = 4'b1001;
    localparam logic [3:0] OP_NOP = 4'b1111;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_OR    = 3'b001;
    localparam logic [2:0] ALUOP_AND   = 3'b010;
    localparam logic [2:0] ALUOP_LUI   = 3'b011;
    localparam logic [2:0] ALUOP_SUB   = 3'b100;
    localparam logic [2:0] ALUOP_JAL   = 3'b101;
    localparam logic [2:0] ALUOP_SLT   = 3'b110;
    localparam logic [2:0] ALUOP_RTYPE = 3'b111;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_mc_sequencer.sv
// Sequences one multi-cycle MULT/DIV on the external HI/LO unit: start pulse,
// PC stall while it runs, and a one-cycle HI/LO capture strobe at the end.
module alu_mc_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned MC_LATENCY = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic mc_req,
    input  logic mc_div,
    input  logic mc_signed,
    input  logic flush,
    output logic mc_start,
    output logic start_div,
    output logic start_signed,
    output logic stall,
    output logic hilo_write,
    output logic busy
);

    // RUN lasts MC_LATENCY-2 cycles; with latency 2 the start goes straight to DONE.
    localparam logic [7:0] LOAD = 8'(MC_LATENCY - 2);

    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       start;

    assign start = (state_q == ST_IDLE) && mc_req && !flush;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d   = LOAD;
                    state_d = (LOAD == 8'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q <= 8'd1) begin
                    state_d = ST_DONE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mc_start     = start;
    assign start_div    = start && mc_div;
    assign start_signed = start && mc_signed;
    assign stall        = start || (state_q == ST_RUN);
    assign hilo_write   = (state_q == ST_DONE) && !flush;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: rtl/alu_control_mc.sv
// MIPS ALU control: combinational ALUOp/funct decode plus the multi-cycle
// multiply/divide sequencer that stalls the PC while HI/LO is computed.
module alu_control_mc
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W    = 3,
    parameter int unsigned FUNCT_W    = 6,
    parameter int unsigned OP_W       = 4,
    parameter int unsigned MC_LATENCY = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ALUOP_W-1:0] ALUOp,
    input  logic [FUNCT_W-1:0] ALUFunction,
    input  logic [4:0]         Shamt,
    input  logic               IssueValid,
    input  logic               Flush,
    output logic [OP_W-1:0]    ALUOperation,
    output logic [4:0]         ShiftAmount,
    output logic               IllegalOp,
    output logic               MCStart,
    output logic               MCDiv,
    output logic               MCSigned,
    output logic               Stall,
    output logic               HiLoWrite,
    output logic               Busy
);

    logic [2:0] aop;
    logic [5:0] fn;
    logic [3:0] op;
    logic       illegal;
    logic       is_mc;

    assign aop = 3'(ALUOp);
    assign fn  = 6'(ALUFunction);

    // Unmatched (including unknown) selectors fall to the default arm, so the
    // ALU sees NOP rather than X.
    always_comb begin
        op      = OP_NOP;
        illegal = 1'b0;
        is_mc   = 1'b0;
        case (aop)
            ALUOP_ADD: op = OP_ADD;
            ALUOP_OR:  op = OP_OR;
            ALUOP_AND: op = OP_AND;
            ALUOP_LUI: op = OP_LUI;
            ALUOP_SUB: op = OP_SUB;
            ALUOP_JAL: op = OP_JAL;
            ALUOP_SLT: op = OP_SLT;
            ALUOP_RTYPE: begin
                case (fn)
                    FN_AND:  op = OP_AND;
                    FN_OR:   op = OP_OR;
                    FN_NOR:  op = OP_NOR;
                    FN_ADD:  op = OP_ADD;
                    FN_SUB:  op = OP_SUB;
                    FN_SLT:  op = OP_SLT;
                    FN_SLL:  op = OP_SLL;
                    FN_SRL:  op = OP_SRL;
                    FN_JR, FN_MFHI, FN_MFLO: op = OP_NOP;
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: is_mc = 1'b1;
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

    assign ALUOperation = OP_W'(op);
    assign IllegalOp    = illegal;
    assign ShiftAmount  = (op == OP_SLL || op == OP_SRL) ? Shamt : 5'd0;

    alu_mc_sequencer #(
        .MC_LATENCY(MC_LATENCY)
    ) u_seq (
        .clk         (clk),
        .reset       (reset),
        .mc_req      (IssueValid && is_mc),
        .mc_div      (fn[1]),
        .mc_signed   (!fn[0]),
        .flush       (Flush),
        .mc_start    (MCStart),
        .start_div   (MCDiv),
        .start_signed(MCSigned),
        .stall       (Stall),
        .hilo_write  (HiLoWrite),
        .busy        (Busy)
    );

endmodule

// File: tb/tb_alu_control_mc.sv
// Self-checking bench for alu_control_mc: decode sweep, directed multi-cycle
// sequences and randomized traffic against a timeline-based reference model.
module tb_alu_control_mc;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] ALUOp;
    logic [5:0] ALUFunction;
    logic [4:0] Shamt;
    logic       IssueValid;
    logic       Flush;
    logic [3:0] ALUOperation;
    logic [4:0] ShiftAmount;
    logic       IllegalOp, MCStart, MCDiv, MCSigned, Stall, HiLoWrite, Busy;

    alu_control_mc #(
        .ALUOP_W   (3),
        .FUNCT_W   (6),
        .OP_W      (4),
        .MC_LATENCY(LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ALUOp       (ALUOp),
        .ALUFunction (ALUFunction),
        .Shamt       (Shamt),
        .IssueValid  (IssueValid),
        .Flush       (Flush),
        .ALUOperation(ALUOperation),
        .ShiftAmount (ShiftAmount),
        .IllegalOp   (IllegalOp),
        .MCStart     (MCStart),
        .MCDiv       (MCDiv),
        .MCSigned    (MCSigned),
        .Stall       (Stall),
        .HiLoWrite   (HiLoWrite),
        .Busy        (Busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the operation tables.
    function automatic void ref_dec(input logic [2:0] a, input logic [5:0] f,
                                    output int op, output int ill, output int mc);
        op  = 15;
        ill = 0;
        mc  = 0;
        case (a)
            3'd0: op = 3;
            3'd1: op = 1;
            3'd2: op = 0;
            3'd3: op = 5;
            3'd4: op = 4;
            3'd5: op = 6;
            3'd6: op = 9;
            default: begin
                case (f)
                    6'h24: op = 0;
                    6'h25: op = 1;
                    6'h27: op = 2;
                    6'h20: op = 3;
                    6'h22: op = 4;
                    6'h2A: op = 9;
                    6'h00: op = 7;
                    6'h02: op = 8;
                    6'h08, 6'h10, 6'h12: op = 15;
                    6'h18, 6'h19, 6'h1A, 6'h1B: mc = 1;
                    default: ill = 1;
                endcase
            end
        endcase
    endfunction

    // Timeline model: a start at cycle t owns cycles t..t+LAT-1.
    int cyc     = 0;
    bit active  = 1'b0;
    int t_start = 0;
    bit pend_start = 1'b0;
    bit pend_flush = 1'b0;

    always @(negedge clk) begin
        int op, ill, mc;
        bit in_seq, es, est, eh;
        ref_dec(ALUOp, ALUFunction, op, ill, mc);
        chk("alu_operation", ALUOperation, op);
        chk("illegal_op", IllegalOp, ill);
        chk("shift_amount", ShiftAmount, (op == 7 || op == 8) ? int'(Shamt) : 0);
        in_seq = active && cyc > t_start && cyc <= t_start + LAT - 1 && !reset;
        es  = !in_seq && IssueValid && mc == 1 && !Flush && !reset;
        est = es || (in_seq && cyc <= t_start + LAT - 2);
        eh  = in_seq && cyc == t_start + LAT - 1 && !Flush;
        chk("mc_start", MCStart, es);
        chk("stall", Stall, est);
        chk("hilo_write", HiLoWrite, eh);
        chk("busy", Busy, in_seq);
        if (es) begin
            chk("mc_div", MCDiv, (ALUFunction == 6'h1A || ALUFunction == 6'h1B));
            chk("mc_signed", MCSigned, (ALUFunction == 6'h18 || ALUFunction == 6'h1A));
        end
        pend_start <= es;
        pend_flush <= in_seq && Flush;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            active <= 1'b0;
        end else begin
            if (pend_start) begin
                active  <= 1'b1;
                t_start <= cyc;
            end else if (pend_flush) begin
                active <= 1'b0;
            end
            cyc <= cyc + 1;
        end
    end

    task automatic drive(input logic [2:0] a, input logic [5:0] f, input logic [4:0] sh,
                         input logic iv, input logic fl);
        @(posedge clk);
        #1;
        ALUOp       = a;
        ALUFunction = f;
        Shamt       = sh;
        IssueValid  = iv;
        Flush       = fl;
    endtask

    initial begin
        int n_start, n_hlw;
        reset       = 1'b1;
        ALUOp       = 3'd0;
        ALUFunction = 6'd0;
        Shamt       = 5'd0;
        IssueValid  = 1'b0;
        Flush       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", Stall, 0);
        chk("reset_busy", Busy, 0);
        chk("reset_hlw", HiLoWrite, 0);
        chk("reset_start", MCStart, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Decode sweep.
        for (int a = 0; a < 7; a++) drive(3'(a), 6'($urandom), 5'($urandom), 1'b0, 1'b0);
        for (int f = 0; f < 64; f++) drive(3'd7, 6'(f), 5'($urandom), 1'b0, 1'b0);

        drive(3'd0, 6'h3F, 5'd0, 1'b0, 1'b0);
        @(negedge clk) chk("addi_op", ALUOperation, 4'b0011);
        drive(3'd7, 6'h2A, 5'd0, 1'b0, 1'b0);
        @(negedge clk) chk("slt_op", ALUOperation, 4'b1001);
        drive(3'd7, 6'h3F, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("f3f_op", ALUOperation, 4'b1111);
        chk("f3f_illegal", IllegalOp, 1);
        drive(3'd7, 6'h00, 5'd7, 1'b0, 1'b0);
        @(negedge clk);
        chk("sll_op", ALUOperation, 4'b0111);
        chk("sll_shamt", ShiftAmount, 7);

        // MULT without IssueValid must not start.
        drive(3'd7, 6'h18, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("noissue_start", MCStart, 0);
        chk("noissue_stall", Stall, 0);

        // MULT: start cycle then LAT cycles of expected sequencer outputs.
        drive(3'd7, 6'h18, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("mult_start", MCStart, 1);
        chk("mult_signed", MCSigned, 1);
        chk("mult_div", MCDiv, 0);
        chk("mult_stall0", Stall, 1);
        for (int i = 1; i <= 4; i++) begin
            drive(3'd7, 6'h20, 5'd0, 1'b0, 1'b0);
            @(negedge clk);
            chk("mult_stall", Stall, (i <= 2) ? 1 : 0);
            chk("mult_hlw", HiLoWrite, (i == 3) ? 1 : 0);
            chk("mult_busy", Busy, (i <= 3) ? 1 : 0);
        end

        // DIVU held on the bus through DONE, then presented again.
        n_start = 0;
        n_hlw   = 0;
        for (int i = 0; i < 4; i++) begin
            drive(3'd7, 6'h1B, 5'd0, 1'b1, 1'b0);
            @(negedge clk);
            n_start += int'(MCStart);
            n_hlw   += int'(HiLoWrite);
            if (i == 0) begin
                chk("divu_div", MCDiv, 1);
                chk("divu_signed", MCSigned, 0);
            end
        end
        chk("divu_starts", n_start, 1);
        chk("divu_hlws", n_hlw, 1);
        drive(3'd7, 6'h1B, 5'd0, 1'b1, 1'b0);
        @(negedge clk) chk("divu_restart", MCStart, 1);
        repeat (4) drive(3'd2, 6'h00, 5'd0, 1'b0, 1'b0);

        // Flush on the second RUN cycle.
        drive(3'd7, 6'h19, 5'd0, 1'b1, 1'b0);
        drive(3'd7, 6'h20, 5'd0, 1'b0, 1'b0);
        drive(3'd7, 6'h20, 5'd0, 1'b0, 1'b1);
        n_hlw = 0;
        @(negedge clk) n_hlw += int'(HiLoWrite);
        drive(3'd7, 6'h20, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("flush_busy", Busy, 0);
        chk("flush_stall", Stall, 0);
        n_hlw += int'(HiLoWrite);
        for (int i = 0; i < 3; i++) begin
            drive(3'd7, 6'h20, 5'd0, 1'b0, 1'b0);
            @(negedge clk) n_hlw += int'(HiLoWrite);
        end
        chk("flush_no_hlw", n_hlw, 0);

        // Asynchronous reset in the middle of RUN.
        drive(3'd7, 6'h1A, 5'd0, 1'b1, 1'b0);
        drive(3'd7, 6'h20, 5'd0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", Busy, 0);
        chk("arst_stall", Stall, 0);
        chk("arst_hlw", HiLoWrite, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        n_hlw = 0;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk) n_hlw += int'(HiLoWrite);
        end
        chk("arst_no_hlw", n_hlw, 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic [2:0] a;
            logic [5:0] f;
            a = ($urandom_range(0, 1) == 0) ? 3'd7 : 3'($urandom);
            f = ($urandom_range(0, 9) < 4) ? 6'(6'h18 + $urandom_range(0, 3)) : 6'($urandom);
            drive(a, f, 5'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0));
        end
        drive(3'd0, 6'd0, 5'd0, 1'b0, 1'b0);
        repeat (LAT + 1) @(posedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
